// File: rtl/denise_pkg.sv
// Shared types and helpers for the AGA Denise colour lookup table.
package denise_pkg;

  localparam logic [8:0] COLORBASE = 9'h180;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } clut_state_t;

  typedef struct packed {
    logic [11:0] hi;
    logic [11:0] lo;
  } clut_entry_t;

  // Interleave the two halves into 8-bit components {R, G, B}.
  function automatic logic [23:0] pack_rgb(input clut_entry_t e);
    return {e.hi[11:8], e.lo[11:8], e.hi[7:4], e.lo[7:4], e.hi[3:0], e.lo[3:0]};
  endfunction

  function automatic logic [23:0] ehb_shift(input logic [23:0] rgb);
    return {1'b0, rgb[23:17], 1'b0, rgb[15:9], 1'b0, rgb[7:1]};
  endfunction

endpackage

// File: rtl/denise_colortable_ram.sv
// 1W/2R synchronous colour RAM: one 12-bit array per half, each with its own write enable.
module denise_colortable_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic [1:0]    we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [23:0]   wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [23:0]   rdata_a_o,
  input  logic          re_b_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [23:0]   rdata_b_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [11:0] mem [2**AW];
      logic [11:0] rd_a_q;
      logic [11:0] rd_b_q;

      // Read-before-write: same-address forwarding is handled by the caller.
      always_ff @(posedge clk) begin
        if (we_i[gi]) mem[waddr_i] <= wdata_i[gi*12 +: 12];
        rd_a_q <= mem[raddr_a_i];
        if (re_b_i) rd_b_q <= mem[raddr_b_i];
      end

      assign rdata_a_o[gi*12 +: 12] = rd_a_q;
      assign rdata_b_o[gi*12 +: 12] = rd_b_q;
    end
  endgenerate

endmodule

// File: rtl/denise_colortable_aga.sv
// AGA colour lookup table: 256 x {hi,lo} entries, init sequencer, 2-clk read with forwarding.
// Optional debug readback port enabled by defining DENISE_CLUT_READBACK_EN.
module denise_colortable_aga
  import denise_pkg::*;
#(
  parameter int SEL_W  = 8,
  parameter int BANK_W = 3,
  parameter int NIB_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk7_en,
  input  logic [8:1]        reg_address_in,
  input  logic [11:0]       data_in,
  input  logic [BANK_W-1:0] bank,
  input  logic              loct,
  input  logic [SEL_W-1:0]  select,
  input  logic [SEL_W-1:0]  sel_xor,
  input  logic              ehb_en,
  output logic [6*NIB_W-1:0] rgb,
  output logic              init_busy
`ifdef DENISE_CLUT_READBACK_EN
  ,
  input  logic              dbg_rd,
  input  logic [SEL_W-1:0]  dbg_adr,
  output logic [23:0]       dbg_dat,
  output logic              dbg_valid
`endif
);

  clut_state_t      state_q, state_d;
  logic [SEL_W-1:0] init_cnt_q, init_cnt_d;

  logic             reg_wr;
  logic [SEL_W-1:0] reg_waddr, ram_waddr, rd_idx, ram_raddr_b;
  logic [1:0]       ram_we;
  logic [23:0]      ram_wdata, ram_rd_b, rgb_q, rgb_d;
  logic             ram_re_b, rd_hb, fwd_hit;
  clut_entry_t      ram_rd_a, entry_s1;

  logic             blank_q, hb_q, fwd_q, fwd_loct_q;
  logic [11:0]      fwd_data_q;

  assign reg_waddr = {bank, reg_address_in[5:1]};
  assign reg_wr    = (state_q == IDLE) && clk7_en && (reg_address_in[8:6] == COLORBASE[8:6]);

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == '1) state_d = IDLE;
    end
  end

  always_comb begin
    ram_we    = '0;
    ram_waddr = reg_waddr;
    ram_wdata = {data_in, data_in};
    if (state_q == INIT) begin
      ram_we    = 2'b11;
      ram_waddr = init_cnt_q;
      ram_wdata = '0;
    end else begin
      ram_we    = {reg_wr & ~loct, reg_wr};
    end
  end

  // In EHB mode only the low five bits address the table; bit 5 selects half-brite.
  always_comb begin
    rd_idx = select ^ sel_xor;
    rd_hb  = 1'b0;
    if (ehb_en) begin
      rd_idx = {{BANK_W{1'b0}}, select[4:0] ^ sel_xor[4:0]};
      rd_hb  = select[5];
    end
  end

  assign fwd_hit = reg_wr && (reg_waddr == rd_idx);

  denise_colortable_ram #(.AW(SEL_W)) u_ram (
    .clk       (clk),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .wdata_i   (ram_wdata),
    .raddr_a_i (rd_idx),
    .rdata_a_o (ram_rd_a),
    .re_b_i    (ram_re_b),
    .raddr_b_i (ram_raddr_b),
    .rdata_b_o (ram_rd_b)
  );

  always_comb begin
    entry_s1 = ram_rd_a;
    if (fwd_q) begin
      entry_s1.lo = fwd_data_q;
      if (!fwd_loct_q) entry_s1.hi = fwd_data_q;
    end
    if (blank_q) entry_s1 = '0;
    rgb_d = hb_q ? ehb_shift(pack_rgb(entry_s1)) : pack_rgb(entry_s1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      blank_q    <= 1'b1;
      hb_q       <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_loct_q <= 1'b0;
      fwd_data_q <= '0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      blank_q    <= (state_q == INIT);
      hb_q       <= rd_hb;
      fwd_q      <= fwd_hit;
      fwd_loct_q <= loct;
      fwd_data_q <= data_in;
      rgb_q      <= rgb_d;
    end
  end

  assign rgb       = rgb_q;
  assign init_busy = (state_q == INIT);

`ifdef DENISE_CLUT_READBACK_EN
  logic dbg_valid_q, dbg_live_q;

  assign ram_re_b    = dbg_rd;
  assign ram_raddr_b = dbg_adr;

  // RAM output is not reset, so mask it until the first debug read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_valid_q <= 1'b0;
      dbg_live_q  <= 1'b0;
    end else begin
      dbg_valid_q <= dbg_rd;
      if (dbg_rd) dbg_live_q <= 1'b1;
    end
  end

  assign dbg_valid = dbg_valid_q;
  assign dbg_dat   = dbg_live_q ? ram_rd_b : 24'h0;
`else
  logic unused_rd_b;

  assign ram_re_b    = 1'b0;
  assign ram_raddr_b = '0;
  assign unused_rd_b = ^ram_rd_b;
`endif

endmodule

// File: tb/tb_denise_colortable_aga.sv
// Self-checking bench for denise_colortable_aga: expected colours are queued as reads are issued.
module tb_denise_colortable_aga;

  logic        clk = 1'b0;
  logic        reset, clk7_en, loct, ehb_en, init_busy;
  logic [8:1]  reg_address_in;
  logic [11:0] data_in;
  logic [2:0]  bank;
  logic [7:0]  select, sel_xor;
  logic [23:0] rgb;
`ifdef DENISE_CLUT_READBACK_EN
  logic        dbg_rd = 1'b0;
  logic [7:0]  dbg_adr = 8'h00;
  logic [23:0] dbg_dat;
  logic        dbg_valid;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [23:0] exp_q[$];
  logic [11:0] m_hi[256];
  logic [11:0] m_lo[256];

  always #5 clk = ~clk;

  denise_colortable_aga dut (
    .clk            (clk),
    .reset          (reset),
    .clk7_en        (clk7_en),
    .reg_address_in (reg_address_in),
    .data_in        (data_in),
    .bank           (bank),
    .loct           (loct),
    .select         (select),
    .sel_xor        (sel_xor),
    .ehb_en         (ehb_en),
    .rgb            (rgb),
    .init_busy      (init_busy)
`ifdef DENISE_CLUT_READBACK_EN
    ,
    .dbg_rd         (dbg_rd),
    .dbg_adr        (dbg_adr),
    .dbg_dat        (dbg_dat),
    .dbg_valid      (dbg_valid)
`endif
  );

  function automatic logic [23:0] model_rgb(input logic [7:0] sel, input logic [7:0] xr, input logic eh);
    logic [7:0]  idx;
    logic [23:0] v;
    idx = eh ? {3'b000, sel[4:0] ^ xr[4:0]} : (sel ^ xr);
    v = {m_hi[idx][11:8], m_lo[idx][11:8], m_hi[idx][7:4], m_lo[idx][7:4], m_hi[idx][3:0], m_lo[idx][3:0]};
    if (eh && sel[5]) v = {1'b0, v[23:17], 1'b0, v[15:9], 1'b0, v[7:1]};
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin
      m_hi[i] = 12'h0;
      m_lo[i] = 12'h0;
    end
  endtask

  // Called at a negedge; one accepted bus write per call.
  task automatic reg_write(input logic [8:0] addr, input logic [11:0] d, input logic [2:0] bk, input logic lo_only);
    logic [7:0] idx;
    reg_address_in = addr[8:1];
    data_in        = d;
    bank           = bk;
    loct           = lo_only;
    clk7_en        = 1'b1;
    @(negedge clk);
    clk7_en = 1'b0;
    if (addr[8:6] == 3'b110) begin
      idx = {bk, addr[5:1]};
      m_lo[idx] = d;
      if (!lo_only) m_hi[idx] = d;
    end
  endtask

  task automatic issue_read(input logic [7:0] sel, input logic [7:0] xr, input logic eh, input logic [23:0] exp);
    select  = sel;
    sel_xor = xr;
    ehb_en  = eh;
    exp_q.push_back(exp);
  endtask

  task automatic test_reset();
    int busy_cnt;
    logic [23:0] e;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb: rgb=%h expected %h", rgb, 24'h0); end
    checks++;
    if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: init_busy=%b expected 1", init_busy); end
    reset    = 1'b0;
    busy_cnt = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 10) begin
        checks++;
        if (rgb !== 24'h0) begin errors++; $display("FAIL init_rgb: rgb=%h expected %h", rgb, 24'h0); end
      end
      if (!init_busy) begin busy_cnt = i; break; end
    end
    checks++;
    if (busy_cnt != 256) begin errors++; $display("FAIL init_len: busy cycles=%0d expected 256", busy_cnt); end
    $display("init: busy for %0d clk", busy_cnt);
    model_clear();
    issue_read(8'hFF, 8'h00, 1'b0, 24'h0);
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rgb !== e) begin errors++; $display("FAIL init_clear_ff: rgb=%h expected %h", rgb, e); end
  endtask

  task automatic test_loct();
    logic [23:0] e;
    reg_write(9'h18A, 12'hABC, 3'd5, 1'b0);
    reg_write(9'h18A, 12'h123, 3'd5, 1'b1);
    issue_read(8'hA5, 8'h00, 1'b0, 24'hA1B2C3);
    @(negedge clk);
    checks++;
    if (rgb !== 24'h0) begin errors++; $display("FAIL loct_latency: rgb=%h expected %h after 1 clk", rgb, 24'h0); end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rgb !== e) begin errors++; $display("FAIL loct_merge: rgb=%h expected %h", rgb, e); end
    $display("loct: sel=a5 rgb=%h", rgb);
  endtask

  task automatic test_ehb();
    logic [23:0] e;
    reg_write(9'h186, 12'hFFF, 3'd0, 1'b0);
    reg_write(9'h186, 12'h5A6, 3'd1, 1'b0);
    issue_read(8'h23, 8'h00, 1'b1, 24'h7F7F7F);
    @(negedge clk);
    issue_read(8'h23, 8'h00, 1'b0, 24'h55AA66);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rgb !== e) begin errors++; $display("FAIL ehb_on: rgb=%h expected %h", rgb, e); end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rgb !== e) begin errors++; $display("FAIL ehb_off: rgb=%h expected %h", rgb, e); end
    $display("ehb: sel=23 ehb=0 rgb=%h", rgb);
  endtask

  task automatic test_xor();
    logic [23:0] e;
    reg_write(9'h186, 12'h456, 3'd0, 1'b0);
    reg_write(9'h1A6, 12'h8C4, 3'd0, 1'b0);
    issue_read(8'h0C, 8'h0F, 1'b0, 24'h445566);
    @(negedge clk);
    issue_read(8'hEC, 8'hFF, 1'b1, 24'h446622);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rgb !== e) begin errors++; $display("FAIL xor_plain: rgb=%h expected %h", rgb, e); end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rgb !== e) begin errors++; $display("FAIL xor_ehb: rgb=%h expected %h", rgb, e); end
    $display("xor: sel=ec xor=ff ehb=1 rgb=%h", rgb);
  endtask

  task automatic test_forwarding();
    logic [23:0] e;
    issue_read(8'h00, 8'h00, 1'b0, 24'h777777);
    reg_write(9'h180, 12'h777, 3'd0, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rgb !== e) begin errors++; $display("FAIL fwd_full: rgb=%h expected %h", rgb, e); end
    issue_read(8'h00, 8'h00, 1'b0, 24'h717273);
    reg_write(9'h180, 12'h123, 3'd0, 1'b1);
    issue_read(8'h00, 8'h00, 1'b0, 24'h717273);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rgb !== e) begin errors++; $display("FAIL fwd_loct: rgb=%h expected %h", rgb, e); end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rgb !== e) begin errors++; $display("FAIL fwd_stored: rgb=%h expected %h", rgb, e); end
    $display("fwd: entry 0 rgb=%h", rgb);
  endtask

  task automatic test_addr_decode();
    logic [23:0] e;
    reg_write(9'h1C0, 12'hEEE, 3'd0, 1'b0);
    reg_address_in = 8'hC1;
    data_in        = 12'hBBB;
    bank           = 3'd0;
    loct           = 1'b0;
    clk7_en        = 1'b0;
    @(negedge clk);
    reg_write(9'h1BE, 12'h9D1, 3'd7, 1'b0);
    issue_read(8'h00, 8'h00, 1'b0, 24'h717273);
    @(negedge clk);
    issue_read(8'h01, 8'h00, 1'b0, 24'h000000);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rgb !== e) begin errors++; $display("FAIL decode_range: rgb=%h expected %h", rgb, e); end
    issue_read(8'hFF, 8'h00, 1'b0, 24'h99DD11);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rgb !== e) begin errors++; $display("FAIL decode_clk7: rgb=%h expected %h", rgb, e); end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rgb !== e) begin errors++; $display("FAIL decode_last: rgb=%h expected %h", rgb, e); end
    $display("decode: entry ff rgb=%h", rgb);
  endtask

  task automatic test_back_to_back();
    logic [23:0] e;
    logic [7:0]  s, x;
    logic        h;
    for (int i = 0; i < 8; i++)
      reg_write(9'h1A0 + 9'(2 * i), 12'($urandom_range(0, 4095)), 3'd2, 1'(i % 2));
    for (int k = 0; k < 16; k++) begin
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        checks++;
        if (rgb !== e) begin errors++; $display("FAIL b2b_%0d: rgb=%h expected %h", k, rgb, e); end
      end
      s = (k % 2 == 0) ? 8'(8'h50 + k / 2) : 8'($urandom);
      x = (k % 3 == 0) ? 8'h00 : 8'($urandom_range(0, 7));
      h = 1'($urandom_range(0, 1));
      issue_read(s, x, h, model_rgb(s, x, h));
      $display("b2b: read %0d sel=%h xor=%h ehb=%b exp=%h", k, s, x, h, model_rgb(s, x, h));
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rgb !== e) begin errors++; $display("FAIL b2b_tail%0d: rgb=%h expected %h", k, rgb, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_during_init();
    int busy_cnt;
    logic [23:0] e;
    issue_read(8'hA5, 8'h00, 1'b0, model_rgb(8'hA5, 8'h00, 1'b0));
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rgb !== e) begin errors++; $display("FAIL rst_pre: rgb=%h expected %h", rgb, e); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rgb !== 24'h0) begin errors++; $display("FAIL rst_rgb: rgb=%h expected %h", rgb, 24'h0); end
    reset = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (init_busy !== 1'b1) begin errors++; $display("FAIL rst_busy: init_busy=%b expected 1", init_busy); end
    reset    = 1'b0;
    busy_cnt = 0;
    for (int i = 1; i <= 400; i++) begin
      if (i == 50) begin
        reg_address_in = 8'hC1;
        data_in        = 12'h999;
        bank           = 3'd0;
        loct           = 1'b0;
        clk7_en        = 1'b1;
      end else begin
        clk7_en = 1'b0;
      end
      @(negedge clk);
      if (i == 60) begin
        checks++;
        if (rgb !== 24'h0) begin errors++; $display("FAIL rst_init_rgb: rgb=%h expected %h", rgb, 24'h0); end
      end
      if (!init_busy) begin busy_cnt = i; break; end
    end
    clk7_en = 1'b0;
    checks++;
    if (busy_cnt != 256) begin errors++; $display("FAIL rst_init_len: busy cycles=%0d expected 256", busy_cnt); end
    $display("reinit: busy for %0d clk", busy_cnt);
    model_clear();
    issue_read(8'h01, 8'h00, 1'b0, 24'h0);
    @(negedge clk);
    issue_read(8'hA5, 8'h00, 1'b0, 24'h0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rgb !== e) begin errors++; $display("FAIL rst_dropped_wr: rgb=%h expected %h", rgb, e); end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rgb !== e) begin errors++; $display("FAIL rst_cleared: rgb=%h expected %h", rgb, e); end
  endtask

  initial begin
    reset          = 1'b1;
    clk7_en        = 1'b0;
    reg_address_in = 8'h00;
    data_in        = 12'h000;
    bank           = 3'd0;
    loct           = 1'b0;
    select         = 8'hFF;
    sel_xor        = 8'h00;
    ehb_en         = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_loct();
    test_ehb();
    test_xor();
    test_forwarding();
    test_addr_decode();
    test_back_to_back();
    test_reset_during_init();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
